// File: rtl/hazard_controller.sv
//------------------------------------------------------------------------------
// hazard_controller
//
// Pipeline hazard unit for a classic 5-stage in-order pipeline. It stalls the
// front end on a load-use dependency, flushes IF/ID (and ID/EX) after a taken
// branch, and freezes the whole pipe while data memory is busy.
//
// Control outputs are combinational in the current state and the inputs.
// The state and the flush counter update on the rising edge of clk.
//
// Ports
//   clk             in   rising-edge clock
//   reset           in   synchronous, active-high reset
//   id_ex_mem_read  in   instruction in ID/EX is a load
//   id_ex_rt        in   load destination register in ID/EX
//   if_id_rs        in   first source register of the instruction in IF/ID
//   if_id_rt        in   second source register of the instruction in IF/ID
//   branch_taken    in   branch resolved taken in EX this cycle
//   mem_busy        in   data memory cannot complete its access this cycle
//   stall_pc        out  hold the PC
//   stall_if_id     out  hold IF/ID
//   stall_id_ex     out  hold ID/EX
//   stall_ex_mem    out  hold EX/MEM
//   flush_if_id     out  load a bubble into IF/ID
//   flush_id_ex     out  load a bubble into ID/EX
//   stall_cycles    out  cycles with stall_pc=1 (saturating)
//   flush_cycles    out  cycles with any flush asserted (saturating)
//
// Parameters
//   BRANCH_PENALTY      IF/ID flush cycles per taken branch, legal 1..3
//   NUM_REGISTERS_LOG2  register specifier width
//
// Build option
//   HAZARD_STATS_EN  when defined, stall_cycles/flush_cycles are live
//                    counters; otherwise both ports are tied to zero.
//------------------------------------------------------------------------------
module hazard_controller #(
   parameter int BRANCH_PENALTY     = 2,
   parameter int NUM_REGISTERS_LOG2 = 5
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          id_ex_mem_read,
   input  logic [NUM_REGISTERS_LOG2-1:0] id_ex_rt,
   input  logic [NUM_REGISTERS_LOG2-1:0] if_id_rs,
   input  logic [NUM_REGISTERS_LOG2-1:0] if_id_rt,
   input  logic                          branch_taken,
   input  logic                          mem_busy,
   output logic                          stall_pc,
   output logic                          stall_if_id,
   output logic                          stall_id_ex,
   output logic                          stall_ex_mem,
   output logic                          flush_if_id,
   output logic                          flush_id_ex,
   output logic [31:0]                   stall_cycles,
   output logic [31:0]                   flush_cycles
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FLUSH    = 2'd2
   } state_t;

   // The branch cycle itself is the first flush cycle; the counter then counts
   // the remaining FLUSH cycles minus one (it exits when it reads zero).
   localparam logic [1:0] FLUSH_LOAD = (BRANCH_PENALTY > 1) ? 2'(BRANCH_PENALTY - 2) : 2'd0;

   state_t     state, state_nxt;
   logic [1:0] flush_cnt, flush_cnt_nxt;
   logic       load_use;

   // Register 0 is hard-wired zero, so a load targeting it never creates a
   // real dependency.
   assign load_use = id_ex_mem_read && (id_ex_rt != '0) &&
                     ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));

   // NOTE: every output of this block gets a default before the case so no
   // path leaves a value unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt     = state;
      flush_cnt_nxt = flush_cnt;
      stall_pc      = 1'b0;
      stall_if_id   = 1'b0;
      stall_id_ex   = 1'b0;
      stall_ex_mem  = 1'b0;
      flush_if_id   = 1'b0;
      flush_id_ex   = 1'b0;

      unique case (state)
         RUN: begin
            if (mem_busy) begin
               {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem} = 4'b1111;
               state_nxt = MEM_WAIT;
            end else if (branch_taken) begin
               flush_if_id = 1'b1;
               flush_id_ex = 1'b1;
               if (BRANCH_PENALTY > 1) begin
                  flush_cnt_nxt = FLUSH_LOAD;
                  state_nxt     = FLUSH;
               end
            end else if (load_use) begin
               // Hold the consumer in IF/ID and send a bubble down to EX.
               stall_pc    = 1'b1;
               stall_if_id = 1'b1;
               flush_id_ex = 1'b1;
            end
         end

         MEM_WAIT: begin
            if (mem_busy) begin
               {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem} = 4'b1111;
            end else begin
               state_nxt = RUN;
            end
         end

         FLUSH: begin
            flush_if_id = 1'b1;
            if (mem_busy) begin
               // Freeze the flush sequence in place while memory is busy.
               {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem} = 4'b1111;
            end else if (flush_cnt == 2'd0) begin
               state_nxt = RUN;
            end else begin
               flush_cnt_nxt = flush_cnt - 2'd1;
            end
         end

         default: state_nxt = RUN;
      endcase

      if (reset) begin
         stall_pc     = 1'b0;
         stall_if_id  = 1'b0;
         stall_id_ex  = 1'b0;
         stall_ex_mem = 1'b0;
         flush_if_id  = 1'b0;
         flush_id_ex  = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= RUN;
         flush_cnt <= 2'd0;
      end else begin
         state     <= state_nxt;
         flush_cnt <= flush_cnt_nxt;
      end
   end

`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] flush_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall_pc && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
         if ((flush_if_id || flush_id_ex) && (flush_cnt_q != '1)) begin
            flush_cnt_q <= flush_cnt_q + 32'd1;
         end
      end
   end

   assign stall_cycles = stall_cnt_q;
   assign flush_cycles = flush_cnt_q;
`else
   assign stall_cycles = '0;
   assign flush_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
//------------------------------------------------------------------------------
// tb_hazard_controller
//
// Drives two hazard_controller instances (BRANCH_PENALTY 2 and 3) from shared
// inputs. Directed scenarios compare against hand-derived values; a random
// phase compares against a behavioural model that tracks "waiting on memory"
// and "flush cycles still owed" rather than the design's state machine.
// Control vector order: {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
//                        flush_if_id, flush_id_ex}.
//------------------------------------------------------------------------------
module tb_hazard_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic       id_ex_mem_read;
   logic [4:0] id_ex_rt, if_id_rs, if_id_rt;
   logic       branch_taken, mem_busy;

   logic [5:0]  ctl2, ctl3;
   logic [31:0] sc2, fc2, sc3, fc3;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   hazard_controller #(.BRANCH_PENALTY(2), .NUM_REGISTERS_LOG2(5)) dut2 (
      .clk(clk), .reset(reset),
      .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
      .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
      .branch_taken(branch_taken), .mem_busy(mem_busy),
      .stall_pc(ctl2[5]), .stall_if_id(ctl2[4]), .stall_id_ex(ctl2[3]),
      .stall_ex_mem(ctl2[2]), .flush_if_id(ctl2[1]), .flush_id_ex(ctl2[0]),
      .stall_cycles(sc2), .flush_cycles(fc2)
   );

   hazard_controller #(.BRANCH_PENALTY(3), .NUM_REGISTERS_LOG2(5)) dut3 (
      .clk(clk), .reset(reset),
      .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
      .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
      .branch_taken(branch_taken), .mem_busy(mem_busy),
      .stall_pc(ctl3[5]), .stall_if_id(ctl3[4]), .stall_id_ex(ctl3[3]),
      .stall_ex_mem(ctl3[2]), .flush_if_id(ctl3[1]), .flush_id_ex(ctl3[0]),
      .stall_cycles(sc3), .flush_cycles(fc3)
   );

   // ---------------- behavioural model ----------------
   int          pen[2]    = '{2, 3};
   bit          m_wait[2];
   int          m_left[2];
   logic [31:0] m_stall[2];
   logic [31:0] m_flush[2];

   logic [5:0]  exp2, exp3, got2, got3;
   logic [31:0] exp_sc2, exp_fc2, exp_sc3, exp_fc3;
   logic [31:0] got_sc2, got_fc2, got_sc3, got_fc3;

   function automatic bit model_hazard();
      return id_ex_mem_read && (id_ex_rt != 0) &&
             (id_ex_rt == if_id_rs || id_ex_rt == if_id_rt);
   endfunction

   function automatic logic [5:0] model_out(input int k);
      if (reset)        return 6'b000000;
      if (m_wait[k])    return mem_busy ? 6'b111100 : 6'b000000;
      if (m_left[k] > 0) return mem_busy ? 6'b111110 : 6'b000010;
      if (mem_busy)     return 6'b111100;
      if (branch_taken) return 6'b000011;
      if (model_hazard()) return 6'b110001;
      return 6'b000000;
   endfunction

   task automatic model_step(input int k, input logic [5:0] o);
      if (reset) begin
         m_wait[k]  = 1'b0;
         m_left[k]  = 0;
         m_stall[k] = 32'd0;
         m_flush[k] = 32'd0;
      end else begin
         if (m_wait[k]) begin
            if (!mem_busy) m_wait[k] = 1'b0;
         end else if (m_left[k] > 0) begin
            if (!mem_busy) m_left[k] = m_left[k] - 1;
         end else if (mem_busy) begin
            m_wait[k] = 1'b1;
         end else if (branch_taken) begin
            m_left[k] = pen[k] - 1;
         end
         if (o[5] && m_stall[k] != 32'hFFFF_FFFF) m_stall[k] = m_stall[k] + 1;
         if ((o[1] || o[0]) && m_flush[k] != 32'hFFFF_FFFF) m_flush[k] = m_flush[k] + 1;
      end
   endtask

   // Apply one cycle of inputs, sample the DUTs mid-cycle, record the model's
   // expectations, then advance the model past the coming rising edge.
   task automatic drive_cycle(input logic rst, input logic rd, input logic [4:0] ert,
                              input logic [4:0] rs, input logic [4:0] rt,
                              input logic br, input logic busy);
      @(negedge clk);
      reset = rst; id_ex_mem_read = rd; id_ex_rt = ert;
      if_id_rs = rs; if_id_rt = rt; branch_taken = br; mem_busy = busy;
      #1;
      got2 = ctl2; got3 = ctl3;
      got_sc2 = sc2; got_fc2 = fc2; got_sc3 = sc3; got_fc3 = fc3;
      exp2 = model_out(0);
      exp3 = model_out(1);
`ifdef HAZARD_STATS_EN
      exp_sc2 = m_stall[0]; exp_fc2 = m_flush[0];
      exp_sc3 = m_stall[1]; exp_fc3 = m_flush[1];
`else
      exp_sc2 = 32'd0; exp_fc2 = 32'd0; exp_sc3 = 32'd0; exp_fc3 = 32'd0;
`endif
      model_step(0, exp2);
      model_step(1, exp3);
   endtask

   task automatic idle();
      drive_cycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      // Reset with every event input active: outputs must stay quiet.
      drive_cycle(1'b1, 1'b1, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1);
      checks++;
      if ({got2, got3} !== 12'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%b/%b want=000000/000000", got2, got3);
      end
      idle();
      checks++;
      if ({got2, got3, got_sc2, got_fc2, got_sc3, got_fc3} !== '0) begin
         failures++;
         $display("FAIL post_reset got=%b/%b stats=%0d,%0d,%0d,%0d want all zero",
                  got2, got3, got_sc2, got_fc2, got_sc3, got_fc3);
      end
   endtask

   task automatic test_load_use();
      drive_cycle(1'b0, 1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0);
      checks++;
      if (got2 !== 6'b110001 || got3 !== 6'b110001) begin
         failures++;
         $display("FAIL load_use_rt got=%b/%b want=110001", got2, got3);
      end
      idle();
      checks++;
      if (got2 !== 6'b000000) begin
         failures++;
         $display("FAIL load_use_release got=%b want=000000", got2);
      end
      drive_cycle(1'b0, 1'b1, 5'd7, 5'd7, 5'd2, 1'b0, 1'b0);
      checks++;
      if (got2 !== 6'b110001) begin
         failures++;
         $display("FAIL load_use_rs got=%b want=110001", got2);
      end
      drive_cycle(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      checks++;
      if (got2 !== 6'b000000 || got3 !== 6'b000000) begin
         failures++;
         $display("FAIL load_r0 got=%b/%b want=000000", got2, got3);
      end
      drive_cycle(1'b0, 1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0);
      checks++;
      if (got2 !== 6'b000000) begin
         failures++;
         $display("FAIL non_load got=%b want=000000", got2);
      end
   endtask

   task automatic test_branch();
      logic [5:0] w2[4] = '{6'b000011, 6'b000010, 6'b000000, 6'b000000};
      logic [5:0] w3[4] = '{6'b000011, 6'b000010, 6'b000010, 6'b000000};
      for (int i = 0; i < 4; i++) begin
         if (i == 0) drive_cycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
         else        idle();
         checks++;
         if (got2 !== w2[i] || got3 !== w3[i]) begin
            failures++;
            $display("FAIL branch_cycle%0d got=%b/%b want=%b/%b", i, got2, got3, w2[i], w3[i]);
         end
      end
   endtask

   task automatic test_mem_busy();
      for (int i = 0; i < 4; i++) begin
         drive_cycle(1'b0, 1'b1, 5'd4, 5'd4, 5'd4, 1'b1, 1'b1);
         checks++;
         if (got2 !== 6'b111100 || got3 !== 6'b111100) begin
            failures++;
            $display("FAIL busy_cycle%0d got=%b/%b want=111100", i, got2, got3);
         end
      end
      // Branch and hazard still present as memory releases: must be ignored.
      drive_cycle(1'b0, 1'b1, 5'd4, 5'd4, 5'd4, 1'b1, 1'b0);
      checks++;
      if (got2 !== 6'b000000 || got3 !== 6'b000000) begin
         failures++;
         $display("FAIL busy_release got=%b/%b want=000000", got2, got3);
      end
      idle();
      checks++;
      if (got2 !== 6'b000000) begin
         failures++;
         $display("FAIL busy_after got=%b want=000000", got2);
      end
   endtask

   task automatic test_flush_busy();
      int n_flush3 = 0;
      logic [5:0] w3[6] = '{6'b000011, 6'b111110, 6'b111110, 6'b000010, 6'b000010, 6'b000000};
      for (int i = 0; i < 6; i++) begin
         drive_cycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, (i == 0), (i == 1 || i == 2));
         if (got3[1]) n_flush3++;
         checks++;
         if (got3 !== w3[i] || got2 !== exp2) begin
            failures++;
            $display("FAIL flush_busy_cycle%0d got=%b/%b want=%b/%b", i, got3, got2, w3[i], exp2);
         end
      end
      checks++;
      if (n_flush3 !== 5) begin
         failures++;
         $display("FAIL flush_busy_total got=%0d want=5", n_flush3);
      end
   endtask

   task automatic test_reset_mid_wait();
      drive_cycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
      drive_cycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
      drive_cycle(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
      checks++;
      if ({got2, got3} !== 12'd0) begin
         failures++;
         $display("FAIL reset_in_wait got=%b/%b want=000000", got2, got3);
      end
      // Back in RUN: a branch must flush immediately.
      drive_cycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
      checks++;
      if (got2 !== 6'b000011 || got3 !== 6'b000011 || got_sc2 !== 0 || got_fc2 !== 0) begin
         failures++;
         $display("FAIL after_reset_wait got=%b/%b stats=%0d,%0d want=000011 stats=0,0",
                  got2, got3, got_sc2, got_fc2);
      end
      repeat (3) idle();
   endtask

`ifdef HAZARD_STATS_EN
   task automatic test_stats();
      drive_cycle(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1'b0, 1'b1, 5'd9, 5'd9, 5'd1, 1'b0, 1'b0);
         idle();
      end
      drive_cycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
      repeat (3) idle();
      checks++;
      if (got_sc2 !== 32'd3 || got_fc2 !== 32'd5 || got_sc3 !== 32'd3 || got_fc3 !== 32'd6) begin
         failures++;
         $display("FAIL stats_count got=%0d,%0d,%0d,%0d want=3,5,3,6",
                  got_sc2, got_fc2, got_sc3, got_fc3);
      end
      @(negedge clk);
      dut2.stall_cnt_q = 32'hFFFF_FFFE;
      dut2.flush_cnt_q = 32'hFFFF_FFFD;
      m_stall[0] = 32'hFFFF_FFFE;
      m_flush[0] = 32'hFFFF_FFFD;
      for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b1, 5'd9, 5'd9, 5'd1, 1'b0, 1'b0);
      idle();
      checks++;
      if (got_sc2 !== 32'hFFFF_FFFF || got_fc2 !== 32'hFFFF_FFFF) begin
         failures++;
         $display("FAIL stats_saturate got=%h,%h want=ffffffff,ffffffff", got_sc2, got_fc2);
      end
   endtask
`endif

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         logic [4:0] ert, rs, rt;
         ert = 5'($urandom_range(0, 3));
         rs  = 5'($urandom_range(0, 3));
         rt  = 5'($urandom_range(0, 3));
         drive_cycle(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1, ert, rs, rt,
                     ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0));
         checks++;
         if (got2 !== exp2 || got3 !== exp3 ||
             got_sc2 !== exp_sc2 || got_fc2 !== exp_fc2 ||
             got_sc3 !== exp_sc3 || got_fc3 !== exp_fc3) begin
            failures++;
            $display("FAIL random_cycle%0d got=%b/%b stats=%0d,%0d,%0d,%0d want=%b/%b stats=%0d,%0d,%0d,%0d",
                     i, got2, got3, got_sc2, got_fc2, got_sc3, got_fc3,
                     exp2, exp3, exp_sc2, exp_fc2, exp_sc3, exp_fc3);
         end
      end
   endtask

   initial begin
      reset = 1'b1; id_ex_mem_read = 1'b0; id_ex_rt = '0;
      if_id_rs = '0; if_id_rt = '0; branch_taken = 1'b0; mem_busy = 1'b0;
      for (int k = 0; k < 2; k++) begin
         m_wait[k] = 1'b0; m_left[k] = 0; m_stall[k] = '0; m_flush[k] = '0;
      end
      test_reset();
      test_load_use();
      test_branch();
      test_mem_busy();
      test_flush_busy();
      test_reset_mid_wait();
`ifdef HAZARD_STATS_EN
      test_stats();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports clk and reset listed first.
REQ-002 Parameter BRANCH_PENALTY, default 2, SHALL set the IF/ID flush cycles per taken branch; legal range 1..3.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous active-high reset, sampled on clk rising edge.
REQ-005 id_ex_mem_read  input  1  instruction in ID/EX is a load.
REQ-006 id_ex_rt  input  NUM_REGISTERS_LOG2  load destination register in ID/EX.
REQ-007 if_id_rs, if_id_rt  input  NUM_REGISTERS_LOG2 each  source registers of the instruction in IF/ID.
REQ-008 branch_taken  input  1  branch resolved taken in EX this cycle.
REQ-009 mem_busy  input  1  data memory cannot complete the current access this cycle.
REQ-010 stall_pc, stall_if_id, stall_id_ex, stall_ex_mem  output  1 each  hold the named register.
REQ-011 flush_if_id, flush_id_ex  output  1 each  load a bubble into the named register.
REQ-012 stall_cycles, flush_cycles  output  32 each  statistics counters (see Configuration).

Function
REQ-013 The block SHALL have three states: RUN, MEM_WAIT, FLUSH, plus a 2-bit flush counter.
REQ-014 Control outputs SHALL be combinational in the current state and inputs; state and counter SHALL update on clk rising edge.
REQ-015 In RUN, priority SHALL be mem_busy > branch_taken > load-use hazard > none.
REQ-016 RUN with mem_busy=1: assert all four stall outputs, no flushes; next state MEM_WAIT.
REQ-017 MEM_WAIT: assert all four stall outputs while mem_busy=1; ignore branch_taken and hazard inputs; when mem_busy=0, deassert all outputs that cycle and return to RUN.
REQ-018 RUN with branch_taken=1 (mem_busy=0): assert flush_if_id and flush_id_ex; if BRANCH_PENALTY>1, load counter with BRANCH_PENALTY-2 and go to FLUSH; otherwise stay in RUN.
REQ-019 FLUSH: assert flush_if_id only; if counter=0 go to RUN, else decrement counter.
REQ-020 FLUSH with mem_busy=1: assert all four stalls and hold flush_if_id; do not change state or counter until mem_busy=0.
REQ-021 Load-use hazard SHALL be: id_ex_mem_read=1 AND id_ex_rt!=0 AND (id_ex_rt==if_id_rs OR id_ex_rt==if_id_rt).
REQ-022 RUN with a load-use hazard and no higher-priority event: assert stall_pc, stall_if_id and flush_id_ex for exactly that cycle; stay in RUN.
REQ-023 Writes to register 0 SHALL never cause a stall.
REQ-024 With no event in RUN, all control outputs SHALL be 0.

Reset
REQ-025 Reset SHALL force state RUN, flush counter 0 and both statistics counters 0, overriding any in-progress MEM_WAIT or FLUSH.
REQ-026 While reset=1, all control outputs SHALL be 0.

Configuration
REQ-027 Macro HAZARD_STATS_EN SHALL compile the statistics counters in.
REQ-028 With HAZARD_STATS_EN: stall_cycles SHALL increment in every cycle with stall_pc=1; flush_cycles SHALL increment in every cycle with flush_if_id=1 or flush_id_ex=1; both SHALL saturate at 32'hFFFFFFFF.
REQ-029 Without HAZARD_STATS_EN: both ports SHALL remain present, tied to 0, with no counter flops.

Verification
REQ-030 Load r5 in ID/EX, if_id_rt=5 -> one cycle of stall_pc=stall_if_id=flush_id_ex=1, then all 0; repeat with id_ex_rt=0 -> no stall.
REQ-031 BRANCH_PENALTY=2, branch_taken pulse -> cycle 0: flush_if_id=flush_id_ex=1; cycle 1: flush_if_id=1 only; cycle 2: all 0.
REQ-032 mem_busy held high 4 cycles with a simultaneous branch_taken and hazard -> 4 cycles of all stalls with no flush; the cycle after mem_busy falls, all outputs 0.
REQ-033 BRANCH_PENALTY=3, mem_busy=1 in first FLUSH cycle -> flush sequence extended by the busy cycles, total flush_if_id cycles = 3 + busy cycles.
REQ-034 reset asserted mid-MEM_WAIT -> outputs 0 on the next cycle, state RUN, counters 0.
REQ-035 With HAZARD_STATS_EN, 3 load-use stalls plus 1 branch (penalty 2) -> stall_cycles=3, flush_cycles=5; with counters preloaded near the maximum -> values saturate at 32'hFFFFFFFF.
